// File: rtl/imem_loader.sv
// Boot-time program loader: streams instruction words into IMEM over a
// valid/ready handshake and holds the CPU in reset until the image is complete.
module imem_loader #(
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned RELEASE_DELAY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        load_valid,
    input  logic [31:0] load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        imem_we,
    output logic [9:0]  imem_addr,
    output logic [31:0] imem_wd,
    output logic        cpu_reset,
    output logic        done,
    output logic        error,
    output logic [10:0] word_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        RUN,
        ERROR
    } state_t;

    localparam logic [10:0] DEPTH_W = 11'(DEPTH);
    localparam logic [3:0]  DELAY_W = 4'(RELEASE_DELAY);

    state_t     state;
    logic [3:0] delay;

    // word_count doubles as the write index: it only ever advances on a write
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            delay      <= '0;
            load_ready <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wd    <= '0;
            cpu_reset  <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, RUN, ERROR: begin
                    if (start) begin
                        state      <= LOAD;
                        load_ready <= 1'b1;
                        word_count <= '0;
                        error      <= 1'b0;
                        done       <= 1'b0;
                        cpu_reset  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (load_valid && load_ready) begin
                        if (word_count == DEPTH_W) begin
                            state      <= ERROR;
                            error      <= 1'b1;
                            load_ready <= 1'b0;
                        end else begin
                            imem_we    <= 1'b1;
                            imem_addr  <= word_count[9:0];
                            imem_wd    <= load_data;
                            word_count <= word_count + 11'd1;
                            if (load_last) begin
                                state      <= FLUSH;
                                load_ready <= 1'b0;
                                delay      <= DELAY_W;
                            end
                        end
                    end
                end
                FLUSH: begin
                    // Release lands RELEASE_DELAY edges after the final write
                    if (delay <= 4'd1) begin
                        state     <= RUN;
                        cpu_reset <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        delay <= delay - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal, bubbled, overflow, reset-abort,
// reload and single-word loads against hand-computed writes and timing.
module tb_imem_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        imem_we;
    logic [9:0]  imem_addr;
    logic [31:0] imem_wd;
    logic        cpu_reset;
    logic        done;
    logic        error;
    logic [10:0] word_count;

    int checks   = 0;
    int failures = 0;

    logic [9:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          stray = 0;
    bit          xfer_pend = 1'b0;

    imem_loader #(.DEPTH(1024), .RELEASE_DELAY(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_last  (load_last),
        .load_ready (load_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wd    (imem_wd),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clock = ~clock;

    // Handshake seen ahead of each rising edge, and the writes that follow it
    always begin
        @(negedge clock);
        #2;
        xfer_pend = load_valid && load_ready && reset;
    end

    always begin
        @(posedge clock);
        #1;
        if (imem_we) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wd);
            if (!xfer_pend) stray++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic stream(input int n, input bit bubbles, input bit with_last, input logic [31:0] base);
        int sent = 0;
        int cyc  = 0;
        bit phase = 1'b1;
        while (sent < n && cyc < 4000) begin
            load_valid = bubbles ? phase : 1'b1;
            phase      = !phase;
            load_data  = base + 32'(sent);
            load_last  = with_last && (sent == n - 1);
            if (load_valid && load_ready) sent++;
            @(negedge clock);
            cyc++;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        check("stream_sent", 32'(sent), 32'(n));
    endtask

    task automatic verify_writes(input string tag, input int n, input logic [31:0] base);
        check({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
            check({tag, "_data"}, wr_data[i], base + 32'(i));
        end
    endtask

    // Samples land on falling edges: first sample follows the final-write edge
    task automatic wait_release(input string tag);
        int k = 0;
        while (cpu_reset === 1'b1 && k < 20) begin
            @(negedge clock);
            k++;
        end
        check({tag, "_release_cycles"}, 32'(k), 32'd2);
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_last  = 1'b0;
        repeat (2) @(negedge clock);

        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wd", imem_wd, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        // Normal load, with valid held high past the last beat
        clear_writes();
        pulse_start();
        check("norm_ready_after_start", 32'(load_ready), 32'd1);
        stream(22, 1'b0, 1'b1, 32'h0800_0000);
        check("norm_ready_after_last", 32'(load_ready), 32'd0);
        check("norm_cpu_reset_flush", 32'(cpu_reset), 32'd1);
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        wait_release("norm");
        repeat (2) @(negedge clock);
        load_valid = 1'b0;
        verify_writes("norm", 22, 32'h0800_0000);
        check("norm_last_word", wr_data.size() >= 22 ? wr_data[21] : 32'h0, 32'h0800_0015);
        check("norm_word_count", 32'(word_count), 32'd22);
        check("norm_cpu_reset_run", 32'(cpu_reset), 32'd0);

        // Reload from RUN
        clear_writes();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
        check("reload_done", 32'(done), 32'd0);
        check("reload_ready", 32'(load_ready), 32'd1);
        check("reload_word_count", 32'(word_count), 32'd0);
        stream(3, 1'b0, 1'b1, 32'hA000_0000);
        wait_release("reload");
        verify_writes("reload", 3, 32'hA000_0000);
        check("reload_word_count_end", 32'(word_count), 32'd3);

        // Single word, with a start pulse while loading
        clear_writes();
        pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("single_ready_after_start", 32'(load_ready), 32'd1);
        check("single_count_after_start", 32'(word_count), 32'd0);
        check("single_no_write_yet", 32'(wr_addr.size()), 32'd0);
        stream(1, 1'b0, 1'b1, 32'h5555_0000);
        wait_release("single");
        verify_writes("single", 1, 32'h5555_0000);
        check("single_word_count", 32'(word_count), 32'd1);

        // Bubbled stream
        clear_writes();
        pulse_start();
        stream(22, 1'b1, 1'b1, 32'h0800_0000);
        wait_release("bubble");
        verify_writes("bubble", 22, 32'h0800_0000);
        check("bubble_word_count", 32'(word_count), 32'd22);
        check("bubble_stray_writes", 32'(stray), 32'd0);

        // Overflow: 1025 words, no last
        clear_writes();
        pulse_start();
        stream(1025, 1'b0, 1'b0, 32'h1000_0000);
        verify_writes("ovf", 1024, 32'h1000_0000);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
        check("ovf_load_ready", 32'(load_ready), 32'd0);
        check("ovf_word_count", 32'(word_count), 32'd1024);
        check("ovf_done", 32'(done), 32'd0);
        pulse_start();
        check("ovf_restart_error", 32'(error), 32'd0);
        check("ovf_restart_ready", 32'(load_ready), 32'd1);

        // Reset mid-load after 5 transfers
        clear_writes();
        stream(5, 1'b0, 1'b0, 32'h7700_0000);
        load_valid = 1'b1;
        load_data  = 32'hBAD0_0000;
        reset      = 1'b0;
        @(negedge clock);
        check("abort_cpu_reset", 32'(cpu_reset), 32'd1);
        check("abort_imem_we", 32'(imem_we), 32'd0);
        check("abort_word_count", 32'(word_count), 32'd0);
        check("abort_load_ready", 32'(load_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (4) @(negedge clock);
        load_valid = 1'b0;
        verify_writes("abort", 5, 32'h7700_0000);
        check("abort_idle_ready", 32'(load_ready), 32'd0);
        check("final_stray_writes", 32'(stray), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
